// File: rtl/rs_cmd_debounce_if.sv
// Command interface for rs_cmd_debounce: raw buttons in, latch commands out.
// Optional RS_CMD_CONFLICT_FLAG_EN adds the sticky conflict flag.
interface rs_cmd_debounce_if;
    logic btn_set;
    logic btn_reset;
    logic s;
    logic r;
    logic busy;
`ifdef RS_CMD_CONFLICT_FLAG_EN
    logic conflict;

    modport master (output btn_set, output btn_reset,
                    input s, input r, input busy, input conflict);
    modport slave  (input btn_set, input btn_reset,
                    output s, output r, output busy, output conflict);
`else
    modport master (output btn_set, output btn_reset,
                    input s, input r, input busy);
    modport slave  (input btn_set, input btn_reset,
                    output s, output r, output busy);
`endif
endinterface

// File: rtl/rs_cmd_debounce.sv
// Command stage in front of the cross-coupled RS latch: synchronises and
// debounces the set/reset buttons and turns each press into a fixed-width
// active-low pulse on s or r, never both at once.
// Optional feature macro: RS_CMD_CONFLICT_FLAG_EN (sticky conflict output).
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no command in flight, s=r=1
// PULSE_S | s held low for PULSE_CYCLES
// PULSE_R | r held low for PULSE_CYCLES
// GAP     | s=r=1 for GAP_CYCLES before the next command
module rs_cmd_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int GAP_CYCLES      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    rs_cmd_debounce_if.slave   cmd
);
    localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PG_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int PG_W   = $clog2(PG_MAX + 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PG_W-1:0] PULSE_LOAD = PG_W'(PULSE_CYCLES - 1);
    localparam logic [PG_W-1:0] GAP_LOAD   = PG_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

    // bit 0 = set channel, bit 1 = reset channel
    logic [1:0]      raw, sync1, sync2, deb, deb_q, press;
    logic [DB_W-1:0] db_cnt [2];
    logic            pend_s, pend_r, req_s, req_r, start_s, start_r;
    logic [PG_W-1:0] pg_cnt;
    logic            s_q, r_q;
    state_t          state, state_nxt;

    assign raw   = {cmd.btn_reset, cmd.btn_set};
    assign press = deb & ~deb_q;

    // Two-flop synchroniser plus per-channel debounce counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Next-state logic; reset requests win over set requests.
    always_comb begin
        state_nxt = state;
        req_r     = pend_r | press[1];
        req_s     = pend_s | press[0];
        case (state)
            IDLE: begin
                if (req_r)      state_nxt = PULSE_R;
                else if (req_s) state_nxt = PULSE_S;
            end
            PULSE_S, PULSE_R: begin
                if (pg_cnt == '0) state_nxt = GAP;
            end
            GAP: begin
                // Leaving GAP makes the same decision IDLE would, so a queued
                // command follows the gap without an extra idle cycle.
                if (pg_cnt == '0) begin
                    if (req_r)      state_nxt = PULSE_R;
                    else if (req_s) state_nxt = PULSE_S;
                    else            state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        start_s = (state_nxt == PULSE_S) && (state != PULSE_S);
        start_r = (state_nxt == PULSE_R) && (state != PULSE_R);
    end

    // State, pulse/gap down-counter, pending flags and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pg_cnt <= '0;
            pend_s <= 1'b0;
            pend_r <= 1'b0;
            s_q    <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                case (state_nxt)
                    PULSE_S, PULSE_R: pg_cnt <= PULSE_LOAD;
                    GAP:              pg_cnt <= GAP_LOAD;
                    default:          pg_cnt <= '0;
                endcase
            end else if (pg_cnt != '0) begin
                pg_cnt <= pg_cnt - PG_W'(1);
            end
            if (start_s)       pend_s <= 1'b0;
            else if (press[0]) pend_s <= 1'b1;
            if (start_r)       pend_r <= 1'b0;
            else if (press[1]) pend_r <= 1'b1;
            s_q <= (state_nxt != PULSE_S);
            r_q <= (state_nxt != PULSE_R);
        end
    end

    assign cmd.s    = s_q;
    assign cmd.r    = r_q;
    assign cmd.busy = (state != IDLE);

`ifdef RS_CMD_CONFLICT_FLAG_EN
    logic conflict_q;

    // Sticky flag: both debounced buttons seen high at the same time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conflict_q <= 1'b0;
        else        conflict_q <= conflict_q | (&deb);
    end

    assign cmd.conflict = conflict_q;
`endif
endmodule

// File: tb/tb_rs_cmd_debounce.sv
// Scoreboard bench for rs_cmd_debounce at default parameters.
module tb_rs_cmd_debounce;
    localparam int LAT = 7;   // stimulus edge -> first low output edge
    localparam int PL  = 2;
    localparam int GP  = 1;

    typedef struct {
        int ch;
        int start;
        int len;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  pulse_q[$];
    ev_t  busy_q[$];
    bit   in_s, in_r, in_b;
    int   st_s, st_r, st_b;

    rs_cmd_debounce_if bus();

    rs_cmd_debounce dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int ch, input int start, input int len);
        ev_t e;
        e = '{ch, start, len};
        pulse_q.push_back(e);
    endtask

    task automatic expect_busy(input int start, input int len);
        ev_t e;
        e = '{0, start, len};
        busy_q.push_back(e);
    endtask

    task automatic close_pulse(input int ch, input int st, input int len);
        ev_t e;
        if (pulse_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: ch=%0d start=%0d len=%0d, expected none", ch, st, len);
        end else begin
            e = pulse_q.pop_front();
            check("pulse_channel", ch, e.ch);
            check("pulse_start", st, e.start);
            check("pulse_len", len, e.len);
        end
    endtask

    task automatic close_busy(input int st, input int len);
        ev_t e;
        if (busy_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_busy: start=%0d len=%0d, expected none", st, len);
        end else begin
            e = busy_q.pop_front();
            check("busy_start", st, e.start);
            check("busy_len", len, e.len);
        end
    endtask

    // Monitor: measures every low pulse and busy window, checks s|r each cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_s = 1'b0;
            in_r = 1'b0;
            in_b = 1'b0;
        end else begin
            check("s_or_r_high", int'(bus.s | bus.r), 1);
            if (!bus.s && !in_s) begin
                in_s = 1'b1; st_s = cyc;
            end else if (bus.s && in_s) begin
                in_s = 1'b0; close_pulse(0, st_s, cyc - st_s);
            end
            if (!bus.r && !in_r) begin
                in_r = 1'b1; st_r = cyc;
            end else if (bus.r && in_r) begin
                in_r = 1'b0; close_pulse(1, st_r, cyc - st_r);
            end
            if (bus.busy && !in_b) begin
                in_b = 1'b1; st_b = cyc;
            end else if (!bus.busy && in_b) begin
                in_b = 1'b0; close_busy(st_b, cyc - st_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus.btn_set   = 1'b0;
        bus.btn_reset = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_s", int'(bus.s), 1);
        check("reset_r", int'(bus.r), 1);
        check("reset_busy", int'(bus.busy), 0);
`ifdef RS_CMD_CONFLICT_FLAG_EN
        check("reset_conflict", int'(bus.conflict), 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: clean set press, held 20 cycles, no pulse on release
        bus.btn_set = 1'b1;
        k = cyc;
        expect_pulse(0, k + LAT, PL);
        expect_busy(k + LAT, PL + GP);
        repeat (20) @(negedge clk);
        bus.btn_set = 1'b0;
        repeat (30) @(negedge clk);

        // 2: bouncing reset button, then stable high
        for (int i = 0; i < 10; i++) begin
            bus.btn_reset = ~bus.btn_reset;
            @(negedge clk);
        end
        bus.btn_reset = 1'b1;
        k = cyc;
        expect_pulse(1, k + LAT, PL);
        expect_busy(k + LAT, PL + GP);
        repeat (20) @(negedge clk);
        bus.btn_reset = 1'b0;
        repeat (30) @(negedge clk);

        // 3: simultaneous press, reset first, set after one gap cycle
        bus.btn_set   = 1'b1;
        bus.btn_reset = 1'b1;
        k = cyc;
        expect_pulse(1, k + LAT, PL);
        expect_pulse(0, k + LAT + PL + GP, PL);
        expect_busy(k + LAT, 2 * (PL + GP));
        repeat (20) @(negedge clk);
        bus.btn_set   = 1'b0;
        bus.btn_reset = 1'b0;
        repeat (30) @(negedge clk);

        // 4: set press landing while r is low
        bus.btn_reset = 1'b1;
        k = cyc;
        repeat (2) @(negedge clk);
        bus.btn_set = 1'b1;
        expect_pulse(1, k + LAT, PL);
        expect_pulse(0, k + LAT + PL + GP, PL);
        expect_busy(k + LAT, 2 * (PL + GP));
        repeat (20) @(negedge clk);
        bus.btn_set   = 1'b0;
        bus.btn_reset = 1'b0;
        repeat (30) @(negedge clk);

        // 5: reset asserted mid-pulse
        bus.btn_set = 1'b1;
        for (int i = 0; i < 20 && bus.s; i++) @(negedge clk);
        check("s_low_before_reset", int'(bus.s), 0);
        #2 rst_n = 1'b0;
        #1;
        check("midpulse_reset_s", int'(bus.s), 1);
        check("midpulse_reset_busy", int'(bus.busy), 0);
        bus.btn_set = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_s", int'(bus.s), 1);
        check("post_reset_r", int'(bus.r), 1);

`ifdef RS_CMD_CONFLICT_FLAG_EN
        // 6: both held -> sticky conflict until reset
        check("conflict_before", int'(bus.conflict), 0);
        bus.btn_set   = 1'b1;
        bus.btn_reset = 1'b1;
        k = cyc;
        expect_pulse(1, k + LAT, PL);
        expect_pulse(0, k + LAT + PL + GP, PL);
        expect_busy(k + LAT, 2 * (PL + GP));
        repeat (10) @(negedge clk);
        check("conflict_held", int'(bus.conflict), 1);
        bus.btn_set   = 1'b0;
        bus.btn_reset = 1'b0;
        repeat (30) @(negedge clk);
        check("conflict_sticky", int'(bus.conflict), 1);
        #2 rst_n = 1'b0;
        #1;
        check("conflict_cleared", int'(bus.conflict), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
`endif

        check("pulses_outstanding", pulse_q.size(), 0);
        check("busy_outstanding", busy_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
